usb_tx_serializer: RTL and testbench

- Transmit-side counterpart of the USB receive datapath: accepts packet bytes over a valid/ready handshake and shifts them out LSB-first, one bit per shift_enable strobe.
- Inserts USB bit stuffing, NRZI-encodes the stream onto d_plus/d_minus, and appends EOP (SE0, SE0, J) after the byte flagged tx_last.
- Upstream supplies every byte, including SYNC (0x80) and PID; this block adds no framing bytes.

---
 rtl/usb_tx_if.sv | 9 +
 rtl/usb_tx_serializer.sv | 93 +++++++++
 tb/tb_usb_tx_serializer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/usb_tx_if.sv
// usb_tx_if: byte handshake between packet source and USB transmit serializer
interface usb_tx_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_last;
  logic tx_ready;
  modport master(output tx_data, tx_valid, tx_last, input tx_ready);
  modport slave(input tx_data, tx_valid, tx_last, output tx_ready);
endinterface

// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer: byte-to-USB serial transmitter with bit stuffing, NRZI and EOP
module usb_tx_serializer #(
  parameter int STUFF_LEN = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input logic clk,
  input logic n_rst,
  input logic shift_enable,
  usb_tx_if.slave bus,
  output logic tx_active,
  output logic tx_error,
  output logic d_orig,
  output logic d_plus,
  output logic d_minus
);
  localparam logic [2:0] IDLE = 3'd0, SHIFT = 3'd1, STUFF = 3'd2, EOP_SE0 = 3'd3, EOP_J = 3'd4;
  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int EW = $clog2(EOP_SE0_BITS + 1);
  logic [2:0] state, bit_idx;
  logic [7:0] hold, shifter;
  logic hold_full, hold_last, cur_last, level;
  logic [OW-1:0] ones;
  logic [EW-1:0] se0_cnt;
  logic accept, in_data, stuff, byte_end, load, emit, emit_bit;
  assign bus.tx_ready = !hold_full;
  assign accept = bus.tx_valid && !hold_full;
  assign d_plus = state != EOP_SE0 && level;
  assign d_minus = state != EOP_SE0 && !level;
  // a byte flagged last never chains into the next one; that byte waits for IDLE
  always_comb begin
    in_data = state == SHIFT || state == STUFF;
    stuff = state == SHIFT && ones == OW'(STUFF_LEN);
    byte_end = in_data && !stuff && bit_idx == 3'd7;
    load = shift_enable && hold_full && (state == IDLE || (byte_end && !cur_last));
    emit = load || (shift_enable && in_data && (stuff || bit_idx != 3'd7));
    emit_bit = load ? hold[0] : (!stuff && shifter[bit_idx + 3'd1]);
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      hold <= '0;
      shifter <= '0;
      hold_full <= 1'b0;
      hold_last <= 1'b0;
      cur_last <= 1'b0;
      level <= 1'b1;
      bit_idx <= '0;
      ones <= '0;
      se0_cnt <= '0;
      tx_active <= 1'b0;
      tx_error <= 1'b0;
      d_orig <= 1'b1;
    end else begin
      tx_error <= 1'b0;
      hold_full <= accept || (hold_full && !load);
      if (accept) begin
        hold <= bus.tx_data;
        hold_last <= bus.tx_last;
      end
      if (emit) begin
        d_orig <= emit_bit;
        level <= emit_bit ? level : !level;
        ones <= emit_bit ? ones + 1'b1 : '0;
      end
      if (load) begin
        shifter <= hold;
        cur_last <= hold_last;
        bit_idx <= '0;
        state <= SHIFT;
        tx_active <= 1'b1;
      end else if (shift_enable) begin
        if (stuff) state <= STUFF;
        else if (in_data && bit_idx != 3'd7) begin
          bit_idx <= bit_idx + 3'd1;
          state <= SHIFT;
        end else if (byte_end) begin
          tx_error <= !cur_last;
          state <= EOP_SE0;
          se0_cnt <= '0;
          level <= 1'b1;
          d_orig <= 1'b1;
          ones <= '0;
        end else if (state == EOP_SE0) begin
          se0_cnt <= se0_cnt + 1'b1;
          if (se0_cnt == EW'(EOP_SE0_BITS - 1)) state <= EOP_J;
        end else if (state == EOP_J) begin
          state <= IDLE;
          tx_active <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_usb_tx_serializer.sv
// tb_usb_tx_serializer: scoreboard bench checking line symbols of each transmitted bit time
module tb_usb_tx_serializer;
  logic clk = 1'b0, n_rst = 1'b0, shift_enable = 1'b0;
  logic d_orig, d_plus, d_minus, tx_active, tx_error;
  usb_tx_if bus();
  usb_tx_serializer dut (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .bus(bus),
    .tx_active(tx_active), .tx_error(tx_error), .d_orig(d_orig),
    .d_plus(d_plus), .d_minus(d_minus)
  );
  typedef struct packed {logic chk; logic orig; logic [1:0] line;} sym_t;
  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;
  sym_t exp_q[$];
  logic [7:0] pkt_q[$];
  int checks = 0, errors = 0, seen = 0, err_cyc = 0, se_cnt = 0;
  bit rand_se = 0;
  logic se_s;
  sym_t e;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    se_cnt = se_cnt + 1;
    shift_enable = rand_se ? ($urandom_range(0, 2) == 0) : (se_cnt % 4 == 0);
    if (tx_error) err_cyc = err_cyc + 1;
  end
  always @(posedge clk) begin
    se_s = shift_enable;
    #1;
    if (se_s && n_rst && tx_active) begin
      seen = seen + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL extra_sym%0d got orig=%b line=%b%b expected none", seen, d_orig, d_plus, d_minus);
      end else begin
        e = exp_q.pop_front();
        if ({d_plus, d_minus} !== e.line || (e.chk && d_orig !== e.orig)) begin
          errors = errors + 1;
          $display("FAIL sym%0d got orig=%b line=%b%b expected orig=%b line=%b", seen, d_orig, d_plus, d_minus, e.orig, e.line);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic push_eop();
    exp_q.push_back({1'b0, 1'b0, SE0});
    exp_q.push_back({1'b0, 1'b0, SE0});
    exp_q.push_back({1'b0, 1'b0, J});
  endtask
  task automatic hand(input int n, input logic [31:0] orig, input logic [31:0] jv);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b1, orig[i], jv[i] ? J : K});
    push_eop();
  endtask
  task automatic model();
    logic lvl = 1'b1;
    int ones = 0;
    logic b;
    foreach (pkt_q[i]) for (int j = 0; j < 8; j++) begin
      b = pkt_q[i][j];
      if (!b) lvl = ~lvl;
      exp_q.push_back({1'b1, b, lvl ? J : K});
      ones = b ? ones + 1 : 0;
      if (ones == 6) begin
        lvl = ~lvl;
        exp_q.push_back({1'b1, 1'b0, lvl ? J : K});
        ones = 0;
      end
    end
    push_eop();
  endtask
  task automatic send(input logic [7:0] b, input logic last);
    int n = 0;
    bus.tx_data = b;
    bus.tx_last = last;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n == 1000) chk("send_timeout", 32'(bus.tx_ready), 32'd1);
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask
  task automatic finish_pkt(input string nm, input int e0, input int exp_err);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
    n = 0;
    while (tx_active && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_active_low"}, 32'(tx_active), 32'd0);
    chk({nm, "_err_pulses"}, 32'(err_cyc - e0), 32'(exp_err));
    exp_q.delete();
  endtask
  initial begin
    int e0, s0, n;
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    bus.tx_last = 1'b0;
    #12;
    chk("rst_d_orig", 32'(d_orig), 32'd1);
    chk("rst_d_plus", 32'(d_plus), 32'd1);
    chk("rst_d_minus", 32'(d_minus), 32'd0);
    chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("rst_tx_active", 32'(tx_active), 32'd0);
    chk("rst_tx_error", 32'(tx_error), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    e0 = err_cyc; hand(8, 32'h80, 32'h2A); send(8'h80, 1'b1); finish_pkt("sync", e0, 0);
    e0 = err_cyc; hand(18, 32'h3DFBF, 32'h3E03F); send(8'hFF, 1'b0); send(8'hFF, 1'b1); finish_pkt("ff_ff", e0, 0);
    e0 = err_cyc; hand(9, 32'h0FC, 32'h0FE); send(8'hFC, 1'b1); finish_pkt("tail_stuff", e0, 0);
    e0 = err_cyc; hand(8, 32'h55, 32'h99); send(8'h55, 1'b0); finish_pkt("underrun", e0, 1);
    e0 = err_cyc; hand(8, 32'h80, 32'h2A); send(8'h80, 1'b1); finish_pkt("after_underrun", e0, 0);
    pkt_q = '{8'hA5};
    model();
    s0 = seen;
    send(8'hA5, 1'b1);
    n = 0;
    while (seen < s0 + 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_bit3_reached", 32'(seen >= s0 + 4), 32'd1);
    #3 n_rst = 1'b0;
    #1;
    chk("mid_rst_d_plus", 32'(d_plus), 32'd1);
    chk("mid_rst_d_minus", 32'(d_minus), 32'd0);
    chk("mid_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("mid_rst_tx_active", 32'(tx_active), 32'd0);
    exp_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    e0 = err_cyc; hand(8, 32'h80, 32'h2A); send(8'h80, 1'b1); finish_pkt("post_rst", e0, 0);
    rand_se = 1;
    for (int p = 0; p < 4; p++) begin
      pkt_q.delete();
      for (int i = 0; i < 4; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
      if (p == 0) pkt_q[1] = 8'hFF;
      e0 = err_cyc;
      model();
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(pkt_q[i], i == 3);
      end
      finish_pkt("stress", e0, 0);
    end
    rand_se = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end
endmodule
